// File: rtl/cordic_phase_sequencer_if.sv
// ============================================================================
// Module : cordic_phase_sequencer_if
// Brief  : Control, CORDIC-core and result-port signal bundle for the
//          CORDIC phase sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface cordic_phase_sequencer_if;
    logic       enable;
    logic [9:0] phase_inc;
    logic [7:0] cordic_angle;
    logic       cordic_run;
    logic [7:0] cordic_cos;
    logic [7:0] cordic_sin;
    logic       cordic_ready;
    logic [8:0] sin_out;
    logic [8:0] cos_out;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       timeout_err;

    modport master (
        output enable, phase_inc, cordic_cos, cordic_sin, cordic_ready, out_ready,
        input  cordic_angle, cordic_run, sin_out, cos_out, out_valid, busy, timeout_err
    );

    modport slave (
        input  enable, phase_inc, cordic_cos, cordic_sin, cordic_ready, out_ready,
        output cordic_angle, cordic_run, sin_out, cos_out, out_valid, busy, timeout_err
    );
endinterface

`default_nettype wire

// File: rtl/cordic_phase_sequencer.sv
// ============================================================================
// Module : cordic_phase_sequencer
// Brief  : Phase accumulator, quadrant folding and result unfolding around a
//          first-quadrant CORDIC core; valid/ready sin/cos output.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cordic_phase_sequencer #(
    parameter int LOAD_CYCLES    = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  wire logic               clk,
    input  wire logic               rst,
    cordic_phase_sequencer_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    localparam int LCNT_W = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam int TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(LOAD_CYCLES - 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]        state_q, state_d;
    logic [9:0]        phase_q, phase_d;
    logic [9:0]        wph_q, wph_d;
    logic [7:0]        angle_q, angle_d;
    logic              run_q, run_d;
    logic [LCNT_W-1:0] lcnt_q, lcnt_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic [8:0]        sin_q, sin_d;
    logic [8:0]        cos_q, cos_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              terr_q, terr_d;

    logic [8:0] s9;
    logic [8:0] c9;
    logic       load_entry;

    assign s9 = {1'b0, bus.cordic_sin};
    assign c9 = {1'b0, bus.cordic_cos};

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        wph_d      = wph_q;
        angle_d    = angle_q;
        lcnt_d     = lcnt_q;
        tcnt_d     = tcnt_q;
        sin_d      = sin_q;
        cos_d      = cos_q;
        valid_d    = valid_q;
        terr_d     = terr_q;
        load_entry = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.enable) begin
                    load_entry = 1'b1;
                end
            end
            S_LOAD: begin
                if (lcnt_q == LCNT_LAST) begin
                    state_d = S_RUN;
                    tcnt_d  = '0;
                end else begin
                    lcnt_d = lcnt_q + 1'b1;
                end
            end
            S_RUN: begin
                // A READY seen in the first RUN cycle may be left over from the previous computation.
                if ((tcnt_q != '0) && bus.cordic_ready) begin
                    valid_d = 1'b1;
                    state_d = S_HOLD;
                    case (wph_q[9:8])
                        2'd0:    begin sin_d = s9;         cos_d = c9;         end
                        2'd1:    begin sin_d = c9;         cos_d = 9'd0 - s9;  end
                        2'd2:    begin sin_d = 9'd0 - s9;  cos_d = 9'd0 - c9;  end
                        default: begin sin_d = 9'd0 - c9;  cos_d = s9;         end
                    endcase
                end else if (tcnt_q == TCNT_LAST) begin
                    // Retry the same working phase; the accumulator has already moved on.
                    terr_d  = 1'b1;
                    state_d = S_LOAD;
                    lcnt_d  = '0;
                    angle_d = wph_q[7:0];
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            default: begin
                if (bus.out_ready) begin
                    valid_d = 1'b0;
                    if (bus.enable) begin
                        load_entry = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
        endcase

        if (load_entry) begin
            wph_d   = phase_q;
            phase_d = phase_q + bus.phase_inc;
            angle_d = phase_q[7:0];
            state_d = S_LOAD;
            lcnt_d  = '0;
        end
    end

    assign run_d  = (state_d == S_RUN);
    assign busy_d = (state_d != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            wph_q   <= '0;
            angle_q <= '0;
            run_q   <= 1'b0;
            lcnt_q  <= '0;
            tcnt_q  <= '0;
            sin_q   <= '0;
            cos_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            wph_q   <= wph_d;
            angle_q <= angle_d;
            run_q   <= run_d;
            lcnt_q  <= lcnt_d;
            tcnt_q  <= tcnt_d;
            sin_q   <= sin_d;
            cos_q   <= cos_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            terr_q  <= terr_d;
        end
    end

    assign bus.cordic_angle = angle_q;
    assign bus.cordic_run   = run_q;
    assign bus.sin_out      = sin_q;
    assign bus.cos_out      = cos_q;
    assign bus.out_valid    = valid_q;
    assign bus.busy         = busy_q;
    assign bus.timeout_err  = terr_q;

endmodule

`default_nettype wire

// File: tb/tb_cordic_phase_sequencer.sv
// ============================================================================
// Module : tb_cordic_phase_sequencer
// Brief  : Scoreboard bench for cordic_phase_sequencer with a behavioural
//          CORDIC-core stand-in and a phase/quadrant reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_cordic_phase_sequencer;

    localparam int LC = 2;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cordic_phase_sequencer_if bus();

    cordic_phase_sequencer #(.LOAD_CYCLES(LC), .TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] ang;
        logic [8:0] s;
        logic [8:0] c;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks    = 0;
    int   errors    = 0;
    int   accepted  = 0;
    int   ref_phase = 0;

    bit fixed_mode  = 1'b0;
    int fix_s       = 0;
    int fix_c       = 0;
    int ready_delay = 2;
    bit rand_delay  = 1'b0;
    bit never_ready = 1'b0;
    int or_mode     = 1;
    bit or_man      = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, expv);
        end
    endtask

    // Core stand-in: magnitudes are an arbitrary function of the angle, or fixed values.
    function automatic int model_s(input int a);
        return fixed_mode ? fix_s : ((a * 37 + 11) % 256);
    endfunction

    function automatic int model_c(input int a);
        return fixed_mode ? fix_c : (255 - a);
    endfunction

    task automatic push_samples(input int n, input int inc);
        exp_t e;
        int a, q, s, c, sv, cv;
        for (int i = 0; i < n; i++) begin
            a = ref_phase % 256;
            q = ref_phase / 256;
            s = model_s(a);
            c = model_c(a);
            case (q)
                0:       begin sv = s;  cv = c;  end
                1:       begin sv = c;  cv = -s; end
                2:       begin sv = -s; cv = -c; end
                default: begin sv = -c; cv = s;  end
            endcase
            e.ang = 8'(a);
            e.s   = sv[8:0];
            e.c   = cv[8:0];
            sb.push_back(e);
            ref_phase = (ref_phase + inc) % 1024;
        end
    endtask

    // CORDIC core model
    initial begin
        int rc;
        int dly;
        rc = 0;
        dly = 1;
        bus.cordic_ready = 1'b0;
        bus.cordic_sin   = 8'd0;
        bus.cordic_cos   = 8'd0;
        forever begin
            @(posedge clk);
            #1;
            bus.cordic_sin = 8'(model_s(int'(bus.cordic_angle)));
            bus.cordic_cos = 8'(model_c(int'(bus.cordic_angle)));
            if (!bus.cordic_run) begin
                rc = 0;
                bus.cordic_ready = 1'b0;
            end else begin
                if (rc == 0) dly = rand_delay ? int'($urandom_range(1, 6)) : ready_delay;
                rc++;
                bus.cordic_ready = !never_ready && (rc >= dly);
            end
        end
    end

    // Consumer ready driver
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (or_mode)
                0:       bus.out_ready = ($urandom_range(0, 2) != 0);
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = or_man;
            endcase
        end
    end

    // Monitor: one scoreboard entry per completed handshake
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            accepted++;
            if (sb.size() == 0) begin
                chk("unexpected_output", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("angle", {24'd0, bus.cordic_angle}, {24'd0, mon_e.ang});
                chk("sin_out", {23'd0, bus.sin_out}, {23'd0, mon_e.s});
                chk("cos_out", {23'd0, bus.cos_out}, {23'd0, mon_e.c});
            end
        end
    end

    task automatic wait_idle(input int target);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 5000; t++) begin
            @(negedge clk);
            if (accepted >= target && !bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wait_idle_timeout", {31'd0, ok}, 32'd1);
        chk("sb_drained", sb.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_samples(input int n, input int inc);
        int start;
        bit ok;
        start = accepted;
        bus.phase_inc = 10'(inc);
        push_samples(n, inc);
        bus.enable = 1'b1;
        if (n == 1) begin
            @(posedge clk);
            #1;
        end else begin
            ok = 1'b0;
            for (int t = 0; t < 5000; t++) begin
                @(negedge clk);
                if (accepted >= start + n - 1) begin
                    ok = 1'b1;
                    break;
                end
            end
            chk("run_timeout", {31'd0, ok}, 32'd1);
            @(posedge clk);
            #1;
        end
        bus.enable = 1'b0;
        wait_idle(start + n);
    endtask

    task automatic start_one();
        bus.enable = 1'b1;
        @(posedge clk);
        #1;
        bus.enable = 1'b0;
    endtask

    task automatic check_latency(input int dly);
        int cnt;
        int start;
        start = accepted;
        ready_delay = dly;
        push_samples(1, int'(bus.phase_inc));
        start_one();
        cnt = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bus.out_valid) break;
            cnt++;
        end
        chk("latency", cnt, LC + ((dly < 2) ? 2 : dly));
        wait_idle(start + 1);
    endtask

    initial begin
        int cnt;
        int start;
        logic [8:0] hs, hc;
        logic [7:0] ha;
        bit ok;

        bus.enable    = 1'b0;
        bus.phase_inc = 10'd0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_angle", {24'd0, bus.cordic_angle}, 32'd0);
        chk("rst_run", {31'd0, bus.cordic_run}, 32'd0);
        chk("rst_sin", {23'd0, bus.sin_out}, 32'd0);
        chk("rst_cos", {23'd0, bus.cos_out}, 32'd0);
        chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_terr", {31'd0, bus.timeout_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Wrap: working phases 0, 300, 600, 900, 176
        or_mode = 1;
        run_samples(5, 300);

        // Bring phase to 210, then walk the four quadrants with fixed magnitudes
        run_samples(1, (210 - ref_phase + 1024) % 1024);
        fixed_mode = 1'b1;
        fix_s = 245;
        fix_c = 73;
        run_samples(4, 256);
        fixed_mode = 1'b0;

        // Reset in RUN discards the sample and clears outputs asynchronously
        push_samples(1, 5);
        bus.phase_inc = 10'd5;
        start_one();
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (bus.cordic_run) begin
                ok = 1'b1;
                break;
            end
        end
        chk("reach_run", {31'd0, ok}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_run", {31'd0, bus.cordic_run}, 32'd0);
        chk("arst_sin", {23'd0, bus.sin_out}, 32'd0);
        chk("arst_cos", {23'd0, bus.cos_out}, 32'd0);
        chk("arst_busy", {31'd0, bus.busy}, 32'd0);
        chk("arst_valid", {31'd0, bus.out_valid}, 32'd0);
        sb.delete();
        ref_phase = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("arst_valid_hold", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_samples(2, 0);

        // Latency from LOAD entry to OUT_VALID
        check_latency(3);
        check_latency(1);
        chk("terr_clear", {31'd0, bus.timeout_err}, 32'd0);

        // Backpressure: OUT_READY low for five HOLD cycles
        start = accepted;
        or_mode = 2;
        or_man = 1'b0;
        ready_delay = 2;
        push_samples(1, int'(bus.phase_inc));
        start_one();
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("bp_valid_seen", {31'd0, ok}, 32'd1);
        hs = bus.sin_out;
        hc = bus.cos_out;
        ha = bus.cordic_angle;
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("bp_sin_stable", {23'd0, bus.sin_out}, {23'd0, hs});
            chk("bp_cos_stable", {23'd0, bus.cos_out}, {23'd0, hc});
            chk("bp_angle_stable", {24'd0, bus.cordic_angle}, {24'd0, ha});
            chk("bp_run_low", {31'd0, bus.cordic_run}, 32'd0);
            chk("bp_not_accepted", accepted, start);
            if (k == 4) or_man = 1'b1;
            @(negedge clk);
        end
        @(negedge clk);
        chk("bp_accepted", accepted, start + 1);
        chk("bp_valid_drop", {31'd0, bus.out_valid}, 32'd0);
        or_mode = 1;
        wait_idle(start + 1);

        // Timeout: core never ready, retry with the same angle, then succeed
        start = accepted;
        never_ready = 1'b1;
        ready_delay = 3;
        push_samples(1, int'(bus.phase_inc));
        start_one();
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (bus.cordic_run) begin
                ok = 1'b1;
                break;
            end
        end
        chk("to_reach_run", {31'd0, ok}, 32'd1);
        cnt = 0;
        for (int t = 0; t < 200; t++) begin
            if (bus.timeout_err) break;
            if (bus.cordic_run) cnt++;
            @(negedge clk);
        end
        chk("to_run_cycles", cnt, TO);
        chk("to_terr", {31'd0, bus.timeout_err}, 32'd1);
        chk("to_run_dropped", {31'd0, bus.cordic_run}, 32'd0);
        chk("to_angle_kept", {24'd0, bus.cordic_angle}, {24'd0, sb[0].ang});
        never_ready = 1'b0;
        wait_idle(start + 1);
        chk("to_terr_sticky", {31'd0, bus.timeout_err}, 32'd1);

        // Randomised segments
        rand_delay = 1'b1;
        or_mode = 0;
        for (int seg = 0; seg < 10; seg++) begin
            run_samples(int'($urandom_range(1, 6)),
                        (seg == 3) ? 0 : int'($urandom_range(0, 1023)));
        end
        chk("final_terr_sticky", {31'd0, bus.timeout_err}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
